// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe_if
// Brief    : Handshake/data bundle between the decode-side producer, the
//            immediate-extension buffer and the ALU-operand consumer.
//            master = producer/consumer side, slave = extension unit.
// Revision : 1.0  initial release
// ============================================================================
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) ();

  // Producer side: immediate/mode offer and the buffer's acceptance.
  logic                         in_valid;
  logic                         in_ready;
  logic [IN_W-1:0]              in_imm;
  logic [1:0]                   in_mode;

  // Consumer side: head entry and the consumer's take strobe.
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_W-1:0]             out_val;
  logic                         out_neg;

  // Occupancy, visible to both sides for stall bookkeeping.
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_val, out_neg, count
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_val, out_neg, count
  );

endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : Pipelined immediate-extension unit. Extends an IN_W-bit
//            immediate to OUT_W bits (sign / zero / upper / branch-offset)
//            and queues results in a DEPTH-entry valid/ready buffer.
//            Optional feature macro: IMM_EXT_BRANCH_EN -- when defined,
//            mode 11 produces the sign-extended value shifted left by 2;
//            when undefined, mode 11 is a plain sign-extend.
// Revision : 1.0  initial release
// ============================================================================
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  imm_extend_pipe_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ext_w = OUT_W - IN_W;

  localparam logic [1:0] c_mode_sign   = 2'b00;
  localparam logic [1:0] c_mode_zero   = 2'b01;
  localparam logic [1:0] c_mode_upper  = 2'b10;
  localparam logic [1:0] c_mode_branch = 2'b11;

  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  generate
    if (IN_W < 2) begin : g_bad_in_w
      $error("imm_extend_pipe: IN_W must be at least 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
      $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("imm_extend_pipe: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Extension datapath (purely combinational from the producer side)
  // --------------------------------------------------------------------------
  logic             w_sign;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_ext;

  assign w_sign  = bus.in_imm[IN_W-1];
  assign w_sext  = {{c_ext_w{w_sign}}, bus.in_imm};
  assign w_zext  = {{c_ext_w{1'b0}}, bus.in_imm};
  assign w_upper = {bus.in_imm, {c_ext_w{1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
  // Word-offset branch: drop the top two sign bits, append two zero LSBs.
  assign w_branch = {w_sext[OUT_W-3:0], 2'b00};
`else
  // Without the shifter, branch mode degenerates to sign-extend.
  assign w_branch = w_sext;
`endif

  // Select the extension result for the requested mode.
  always_comb begin
    w_ext = w_sext;
    case (bus.in_mode)
      c_mode_sign:   w_ext = w_sext;
      c_mode_zero:   w_ext = w_zext;
      c_mode_upper:  w_ext = w_upper;
      c_mode_branch: w_ext = w_branch;
      default:       w_ext = w_sext;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result buffer: circular array with separate read/write pointers
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [OUT_W-1:0]   w_out_val;

  // Readiness comes only from registered occupancy, so a stall on the
  // consumer side never ripples combinationally back into decode.
  assign w_in_ready  = (r_count < c_cnt_full);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // Capture the extended value into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_ext;
    end
  end

  // Advance pointers and track occupancy; reset discards all entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Consumer-facing outputs (registered state only)
  // --------------------------------------------------------------------------
  // Stale slot contents are masked so an empty buffer always shows zero.
  assign w_out_val = w_out_valid ? r_mem[r_rptr] : '0;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_val   = w_out_val;
  assign bus.out_neg   = w_out_val[OUT_W-1];
  assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Scoreboard bench for imm_extend_pipe (IN_W=16, OUT_W=32,
//            DEPTH=2). Expected branch-mode results follow the
//            IMM_EXT_BRANCH_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;

  localparam logic [1:0] M_SIGN   = 2'b00;
  localparam logic [1:0] M_ZERO   = 2'b01;
  localparam logic [1:0] M_UPPER  = 2'b10;
  localparam logic [1:0] M_BRANCH = 2'b11;

`ifdef IMM_EXT_BRANCH_EN
  localparam logic [31:0] EXP_BR_FFFF = 32'hFFFF_FFFC;
  localparam logic [31:0] EXP_BR_0004 = 32'h0000_0010;
`else
  localparam logic [31:0] EXP_BR_FFFF = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_BR_0004 = 32'h0000_0004;
`endif

  logic clk;
  logic reset;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every transfer the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 64'(bus.out_valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_val", 64'(bus.out_val), 64'(mon_exp));
        check("out_neg", 64'(bus.out_neg), 64'(mon_exp[31]));
      end
    end
  end

  // Offer one immediate; starts just after a rising edge, ends on the next.
  task automatic try_push(input logic [15:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp, output bit acc);
    bit r;
    #1;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    @(negedge clk);
    r = bus.in_ready;
    @(posedge clk);
    acc = r;
    if (r) exp_q.push_back(exp);
  endtask

  task automatic drop();
    #1 bus.in_valid = 1'b0;
  endtask

  // Let the consumer empty the buffer, then confirm the empty state.
  task automatic drain(input string tag);
    int k;
    k = 0;
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({tag, "_empty_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_empty_count"}, 64'(bus.count), 64'd0);
    check({tag, "_empty_val"},   64'(bus.out_val), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = M_SIGN;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_val",   64'(bus.out_val),   64'd0);
    check("rst_out_neg",   64'(bus.out_neg),   64'd0);
    check("rst_count",     64'(bus.count),     64'd0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);

    // Extension modes, streaming with out_ready high
    try_push(16'h8000, M_SIGN, 32'hFFFF_8000, acc);
    check("sign_accept", 64'(acc), 64'd1);
    drop();
    @(negedge clk);
    check("latency_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    try_push(16'h7FFF, M_SIGN,   32'h0000_7FFF, acc);
    try_push(16'h8000, M_ZERO,   32'h0000_8000, acc);
    try_push(16'h1234, M_UPPER,  32'h1234_0000, acc);
    try_push(16'hFFFF, M_BRANCH, EXP_BR_FFFF,   acc);
    try_push(16'h0004, M_BRANCH, EXP_BR_0004,   acc);
    check("stream_accept", 64'(acc), 64'd1);
    drain("modes");

    // Back-pressure: fill with out_ready low, third offer refused
    #1 bus.out_ready = 1'b0;
    try_push(16'h0001, M_SIGN, 32'h0000_0001, acc);
    check("bp_accept1", 64'(acc), 64'd1);
    try_push(16'h0002, M_SIGN, 32'h0000_0002, acc);
    check("bp_accept2", 64'(acc), 64'd1);
    try_push(16'h0003, M_SIGN, 32'h0000_0003, acc);
    check("bp_refuse3", 64'(acc), 64'd0);
    @(negedge clk);
    check("bp_full_count", 64'(bus.count),    64'd2);
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 5) begin
      try_push(16'h0003, M_SIGN, 32'h0000_0003, acc);
      k++;
    end
    check("bp_retry_tries", 64'(k), 64'd2);
    drain("bp");

    // Simultaneous push and pop at count=1
    #1 bus.out_ready = 1'b0;
    try_push(16'h0011, M_SIGN, 32'h0000_0011, acc);
    drop();
    @(negedge clk);
    check("pp_count_before", 64'(bus.count), 64'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    try_push(16'h0022, M_SIGN, 32'h0000_0022, acc);
    check("pp_accept_b", 64'(acc), 64'd1);
    try_push(16'h0033, M_SIGN, 32'h0000_0033, acc);
    check("pp_accept_c", 64'(acc), 64'd1);
    drop();
    @(negedge clk);
    check("pp_count_after", 64'(bus.count), 64'd1);
    @(posedge clk);
    drain("pp");

    // Reset mid-operation with a full buffer
    #1 bus.out_ready = 1'b0;
    try_push(16'h0AAA, M_SIGN, 32'h0000_0AAA, acc);
    try_push(16'h0BBB, M_SIGN, 32'h0000_0BBB, acc);
    drop();
    @(negedge clk);
    check("mid_count_full", 64'(bus.count), 64'd2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("mid_rst_out_val",   64'(bus.out_val),   64'd0);
    check("mid_rst_out_neg",   64'(bus.out_neg),   64'd0);
    check("mid_rst_count",     64'(bus.count),     64'd0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    try_push(16'h00FF, M_SIGN, 32'h0000_00FF, acc);
    check("post_rst_accept", 64'(acc), 64'd1);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. Takes an IN_W-bit instruction immediate plus a mode select and produces an OUT_W-bit operand. Modes: sign-extend, zero-extend, upper-load and branch-offset. Results pass through a DEPTH-entry valid/ready buffer, so the unit sits between decode and the ALU-operand mux of the multi-cycle and pipelined cores and absorbs back-pressure from stalls.

## Interface
Parameters:
- IN_W, 16, immediate width; ≥ 2.
- OUT_W, 32, result width; must satisfy OUT_W ≥ IN_W + 2.
- DEPTH, 2, result buffer entries; power of 2, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  the immediate/mode pair is offered.
- in_ready  out  1  the buffer can accept; high iff count < DEPTH.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  out  1  the head entry is valid; high iff count > 0.
- out_ready  in  1  the consumer takes the head entry.
- out_val  out  OUT_W  extended result at the head; 0 when empty.
- out_neg  out  1  out_val[OUT_W-1]; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Push: in_valid && in_ready at a rising edge. The extended value is computed combinationally from in_imm/in_mode and written at the write pointer. The write pointer then increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge. The read pointer increments modulo DEPTH.
- Extension rules (s = in_imm[IN_W-1]):
  - sign: {(OUT_W-IN_W){s}, in_imm}.
  - zero: {(OUT_W-IN_W){0}, in_imm}.
  - upper: in_imm << (OUT_W-IN_W); the low bits are zero; the top IN_W bits equal in_imm.
  - branch: the sign-extended value shifted left by 2, truncated to OUT_W; the two LSBs are 0.
- Occupancy rules:
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Push with pop while full cannot occur, because in_ready is low. This holds even when out_ready is high; there is no full-bypass.
  - Pop while empty: ignored; pointers and count hold.
  - in_valid while in_ready is low: no state change. The producer must hold its data.
- FIFO order is strict. Every accepted input appears exactly once at the output, in order.
- Reset (asserted at any time, including mid-transfer):
  - count = 0, pointers = 0.
  - out_valid = 0, in_ready = 1, out_val = 0, out_neg = 0.
  - Buffered entries are discarded.

## Timing
- Latency: an input accepted at edge N is visible on out_val/out_valid after edge N, i.e. usable at edge N+1. The output is registered; there is no combinational path from in_* to out_*.
- in_ready depends only on registered count. It has no combinational dependence on out_ready.
- Throughput: one transfer per cycle in steady state when out_ready is held high.
- With out_ready low, DEPTH pushes fill the buffer. in_ready falls after the DEPTH-th push edge.
- After a pop from full, in_ready rises in the following cycle.
- Reset acts immediately (asynchronous). Deassertion is synchronised externally; the first push is legal on the first edge after reset is released.

## Configuration
- IMM_EXT_BRANCH_EN defined: mode 11 performs the branch-offset extension described above.
- IMM_EXT_BRANCH_EN undefined: the shift logic is omitted and mode 11 behaves exactly as mode 00 (sign-extend). All other behaviour is identical.

## Test plan
All scenarios use IN_W=16, OUT_W=32, DEPTH=2.
- Sign mode: push 0x8000 with out_ready=1 → next cycle out_val=0xFFFF8000, out_neg=1. Then push 0x7FFF → out_val=0x00007FFF, out_neg=0.
- Zero and upper modes: zero with 0x8000 → 0x00008000. Upper with 0x1234 → 0x12340000.
- Branch mode: 0xFFFF → 0xFFFFFFFC, and 0x0004 → 0x00000010. With IMM_EXT_BRANCH_EN undefined, 0xFFFF → 0xFFFFFFFF.
- Back-pressure:
  - Hold out_ready=0 and offer 0x0001, 0x0002, 0x0003 back-to-back (sign mode).
  - Expect count=2 and in_ready=0; 0x0003 is not accepted.
  - Raise out_ready; outputs appear in order 0x00000001, 0x00000002, 0x00000003. count returns to 0 and out_val=0.
- Simultaneous push and pop at count=1: count stays 1, order is preserved, no entry is lost or duplicated.
- Reset mid-operation: with count=2, assert reset between clock edges → immediately out_valid=0, in_ready=1, out_val=0, count=0. After release, a fresh push of 0x00FF yields 0x000000FF.
